// File: rtl/stopwatch_ctrl.sv
// Sequencing controller for the MM:SS stopwatch: input conditioning, 1 Hz / 2 Hz strobes,
// RUN/PAUSED/ADJUST state machine and adjust-mode blink for the display driver.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_c,
    input  logic       reset_c,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_adj,
    input  logic [1:0] sw_sel,
    output logic       cnt_en,
    output logic       adj_inc,
    output logic [1:0] adj_sel,
    output logic       clr_o,
    output logic       paused_o,
    output logic       adj_o,
    output logic       blink_on
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned BW = $clog2(CLK_HZ / 4);

    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(CLK_HZ / 4 - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PAUSED,
        S_ADJUST
    } state_t;

    // Channel order: 0 pause, 1 clear, 2 adjust switch
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    db;
    logic [DW-1:0] dcnt [3];
    logic [1:0]    db_d;
    logic [1:0]    press;
    logic [1:0]    sel1;
    logic [1:0]    sel2;

    logic          pause_ev;
    logic          clr_ev;
    logic          adj_lvl;

    state_t        state;
    state_t        nxt_state;
    logic          resume_paused;
    logic          nxt_resume;
    logic [PW-1:0] presc;
    logic          tick1;
    logic          tick2;
    logic [BW-1:0] bcnt;

    assign raw      = {sw_adj, btn_clr, btn_pause};
    assign pause_ev = press[0];
    assign clr_ev   = press[1];
    assign adj_lvl  = db[2];

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            sel1  <= '0;
            sel2  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            sel1  <= sw_sel;
            sel2  <= sel1;
            // Any cycle agreeing with the accepted level restarts the stability count
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != db[i]) begin
                    if (dcnt[i] == D_LAST) begin
                        db[i]   <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
            db_d  <= db[1:0];
            press <= db[1:0] & ~db_d;
        end
    end

    assign tick1 = (presc == P_LAST);
    assign tick2 = tick1 || (presc == P_HALF);

    // Next state is decoded here so the mode flags and blink register align with the state itself
    always_comb begin
        nxt_state  = state;
        nxt_resume = resume_paused;
        case (state)
            S_RUN: begin
                if (adj_lvl) begin
                    nxt_state  = S_ADJUST;
                    nxt_resume = 1'b0;
                end else if (pause_ev) begin
                    nxt_state = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (adj_lvl) begin
                    nxt_state  = S_ADJUST;
                    nxt_resume = 1'b1;
                end else if (pause_ev) begin
                    nxt_state = S_RUN;
                end
            end
            S_ADJUST: begin
                if (!adj_lvl) begin
                    nxt_state = resume_paused ? S_PAUSED : S_RUN;
                end
            end
            default: nxt_state = S_RUN;
        endcase
    end

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            state         <= S_RUN;
            resume_paused <= 1'b0;
            presc         <= '0;
            bcnt          <= '0;
            cnt_en        <= 1'b0;
            adj_inc       <= 1'b0;
            adj_sel       <= '0;
            clr_o         <= 1'b0;
            paused_o      <= 1'b0;
            adj_o         <= 1'b0;
            blink_on      <= 1'b1;
        end else begin
            state         <= nxt_state;
            resume_paused <= nxt_resume;

            // Clear restarts the second and swallows any tick due this cycle
            if (clr_ev) begin
                presc <= '0;
            end else if (state != S_PAUSED) begin
                presc <= tick1 ? '0 : presc + 1'b1;
            end

            cnt_en   <= tick1 && (state == S_RUN) && !clr_ev;
            adj_inc  <= tick2 && (state == S_ADJUST) && !clr_ev;
            adj_sel  <= sel2;
            clr_o    <= clr_ev;
            paused_o <= (nxt_state == S_PAUSED);
            adj_o    <= (nxt_state == S_ADJUST);

            if ((nxt_state == S_ADJUST) && (state == S_ADJUST)) begin
                if (bcnt == B_LAST) begin
                    bcnt     <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                bcnt     <= '0;
                blink_on <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: scenario tasks plus random stimulus, each compared
// against a cycle-level reference model built from input history windows.
module tb_stopwatch_ctrl;

    localparam int unsigned CLK_HZ = 8;
    localparam int unsigned DEB    = 4;

    logic       clk_c     = 1'b0;
    logic       reset_c   = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_clr   = 1'b0;
    logic       sw_adj    = 1'b0;
    logic [1:0] sw_sel    = 2'b00;
    logic       cnt_en, adj_inc, clr_o, paused_o, adj_o, blink_on;
    logic [1:0] adj_sel;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    stopwatch_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_c    (clk_c),
        .reset_c  (reset_c),
        .btn_pause(btn_pause),
        .btn_clr  (btn_clr),
        .sw_adj   (sw_adj),
        .sw_sel   (sw_sel),
        .cnt_en   (cnt_en),
        .adj_inc  (adj_inc),
        .adj_sel  (adj_sel),
        .clr_o    (clr_o),
        .paused_o (paused_o),
        .adj_o    (adj_o),
        .blink_on (blink_on)
    );

    always #5 clk_c = ~clk_c;

    // {cnt_en, adj_inc, adj_sel[1:0], clr_o, paused_o, adj_o, blink_on}
    logic [7:0] obs;
    assign obs = {cnt_en, adj_inc, adj_sel, clr_o, paused_o, adj_o, blink_on};
    localparam logic [7:0] RESET_VEC = 8'h01;

    // Reference model: debounced level flips when the last DEB synchronized samples all
    // disagree with it; a press acts on the FSM two edges after the level rises.
    typedef enum int {M_RUN, M_PAUSED, M_ADJUST} mstate_t;
    mstate_t         m_state;
    logic            m_resume;
    int unsigned     m_phase, m_age;
    logic [2:0]      m_db;
    logic [DEB+1:0]  m_hist [3];
    logic [1:0]      sel_h [3];
    logic [1:0]      p_rise, c_rise;
    logic [7:0]      m_exp;

    task automatic model_reset();
        m_state  = M_RUN;
        m_resume = 1'b0;
        m_phase  = 0;
        m_age    = 0;
        m_db     = '0;
        p_rise   = '0;
        c_rise   = '0;
        for (int c = 0; c < 3; c++) begin
            m_hist[c] = '0;
            sel_h[c]  = '0;
        end
        m_exp = RESET_VEC;
    endtask

    task automatic model_update();
        logic           pev, cev, adj_lvl;
        mstate_t        nxt;
        logic [2:0]     raw, new_db;
        logic [DEB-1:0] win;
        if (reset_c) begin
            model_reset();
            return;
        end
        pev     = p_rise[1];
        cev     = c_rise[1];
        adj_lvl = m_db[2];
        m_exp[7] = (m_state == M_RUN) && (m_phase == CLK_HZ - 1) && !cev;
        m_exp[6] = (m_state == M_ADJUST) &&
                   ((m_phase == CLK_HZ - 1) || (m_phase == CLK_HZ / 2 - 1)) && !cev;
        sel_h[2] = sel_h[1];
        sel_h[1] = sel_h[0];
        sel_h[0] = sw_sel;
        m_exp[5:4] = sel_h[2];
        m_exp[3]   = cev;
        nxt = m_state;
        case (m_state)
            M_RUN:    if (adj_lvl) begin nxt = M_ADJUST; m_resume = 1'b0; end
                      else if (pev) nxt = M_PAUSED;
            M_PAUSED: if (adj_lvl) begin nxt = M_ADJUST; m_resume = 1'b1; end
                      else if (pev) nxt = M_RUN;
            default:  if (!adj_lvl) nxt = m_resume ? M_PAUSED : M_RUN;
        endcase
        if (cev) m_phase = 0;
        else if (m_state != M_PAUSED) m_phase = (m_phase + 1) % CLK_HZ;
        if (nxt == M_ADJUST && m_state == M_ADJUST) m_age++;
        else m_age = 0;
        m_exp[2] = (nxt == M_PAUSED);
        m_exp[1] = (nxt == M_ADJUST);
        m_exp[0] = (nxt != M_ADJUST) || (((m_age / (CLK_HZ / 4)) % 2) == 0);
        m_state  = nxt;
        raw    = {sw_adj, btn_clr, btn_pause};
        new_db = m_db;
        for (int c = 0; c < 3; c++) begin
            m_hist[c] = {m_hist[c][DEB:0], raw[c]};
            win = m_hist[c][DEB+1:2];
            if (win == '1) new_db[c] = 1'b1;
            else if (win == '0) new_db[c] = 1'b0;
        end
        p_rise = {p_rise[0], new_db[0] & ~m_db[0]};
        c_rise = {c_rise[0], new_db[1] & ~m_db[1]};
        m_db   = new_db;
    endtask

    task automatic step();
        @(posedge clk_c);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) step();
        n_checks++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", obs, RESET_VEC);
        end
        reset_c = 1'b0;
    endtask

    task automatic test_run();
        int first = -1, last = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL run_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
            if (cnt_en) begin
                if (first < 0) first = i;
                else begin
                    n_checks++;
                    if (i - last != CLK_HZ) begin
                        n_fail++;
                        $display("FAIL run_period got=%0d exp=%0d", i - last, CLK_HZ);
                    end
                end
                last = i;
            end
        end
        n_checks++;
        if (first != CLK_HZ) begin
            n_fail++;
            $display("FAIL run_first_cnt_en got=%0d exp=%0d", first, CLK_HZ);
        end
    endtask

    task automatic test_debounce_pause();
        int unsigned rises = 0, lat = 0;
        logic prev = paused_o;
        repeat ($urandom_range(2, 4)) begin
            btn_pause = 1'b1;
            repeat ($urandom_range(1, DEB - 1)) begin
                step();
                n_checks++;
                if (obs !== m_exp) begin
                    n_fail++;
                    $display("FAIL bounce_model t=%0t got=%b exp=%b", $time, obs, m_exp);
                end
                if (paused_o && !prev) rises++;
                prev = paused_o;
            end
            btn_pause = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                step();
                n_checks++;
                if (obs !== m_exp) begin
                    n_fail++;
                    $display("FAIL bounce_model t=%0t got=%b exp=%b", $time, obs, m_exp);
                end
                if (paused_o && !prev) rises++;
                prev = paused_o;
            end
        end
        btn_pause = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            if (j == 21) btn_pause = 1'b0;
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL hold_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
            if (paused_o && !prev) begin
                rises++;
                if (lat == 0) lat = j;
            end
            prev = paused_o;
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL pause_event_count got=%0d exp=1", rises);
        end
        n_checks++;
        if (lat != DEB + 4) begin
            n_fail++;
            $display("FAIL pause_latency got=%0d exp=%0d", lat, DEB + 4);
        end
        btn_pause = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            if (j == DEB + 7) btn_pause = 1'b0;
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL resume_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
        end
        n_checks++;
        if (paused_o !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_state got=%b exp=0", paused_o);
        end
    endtask

    task automatic test_adjust(input logic [1:0] sel);
        int last = -1;
        sw_sel = sel;
        sw_adj = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            if (j == 40) sw_adj = 1'b0;
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL adjust_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
            if (adj_inc) begin
                n_checks++;
                if (adj_sel !== sel || cnt_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL adjust_sel got=%b/%b exp=%b/0", adj_sel, cnt_en, sel);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (j - last != CLK_HZ / 2) begin
                        n_fail++;
                        $display("FAIL adjust_period got=%0d exp=%0d", j - last, CLK_HZ / 2);
                    end
                end
                last = j;
            end
        end
        n_checks++;
        if ({adj_o, paused_o} !== 2'b00 || last < 0) begin
            n_fail++;
            $display("FAIL adjust_exit got=%b%b seen_inc=%0d exp=00", adj_o, paused_o, last >= 0);
        end
    endtask

    task automatic test_adjust_from_paused();
        for (int j = 1; j <= 90; j++) begin
            btn_pause = (j <= 10) || (j > 40 && j <= 50) || (j > 80);
            sw_adj    = (j > 25 && j <= 60);
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL adj_paused_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
            if (j == 20 || j == 38 || j == 75) begin
                n_checks++;
                if ({paused_o, adj_o} !== ((j == 38) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL adj_paused_state j=%0d got=%b%b", j, paused_o, adj_o);
                end
            end
        end
        btn_pause = 1'b0;
        repeat (12) step();
        n_checks++;
        if (paused_o !== 1'b0) begin
            n_fail++;
            $display("FAIL adj_paused_resume got=%b exp=0", paused_o);
        end
    endtask

    task automatic test_clear();
        int clr_at = -1, n_clr = 0, cnt_after = -1;
        for (int k = 0; k < 16 && m_phase != 6; k++) step();
        btn_clr = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            if (j == 11) btn_clr = 1'b0;
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL clear_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
            if (clr_o) begin n_clr++; clr_at = j; end
            if (cnt_en && clr_at > 0 && cnt_after < 0) cnt_after = j - clr_at;
        end
        n_checks++;
        if (n_clr != 1 || clr_at != DEB + 4) begin
            n_fail++;
            $display("FAIL clear_pulse got=%0d@%0d exp=1@%0d", n_clr, clr_at, DEB + 4);
        end
        n_checks++;
        if (cnt_after != CLK_HZ || paused_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_restart got=%0d paused=%b exp=%0d", cnt_after, paused_o, CLK_HZ);
        end
    endtask

    task automatic test_back_to_back();
        int clr_at = -1, pause_at = -1;
        logic seen_paused = 1'b0;
        logic prev = paused_o;
        for (int j = 1; j <= 60; j++) begin
            btn_clr   = (j <= 10);
            btn_pause = (j <= 10) || (j > 25 && j <= 35);
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL both_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
            if (clr_o) clr_at = j;
            if (paused_o && !prev) pause_at = j;
            prev = paused_o;
        end
        n_checks++;
        if (clr_at != pause_at || clr_at < 0 || paused_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_and_pause got=%0d/%0d exp equal", clr_at, pause_at);
        end
        // pause event and adjust rise reach the state machine on the same edge
        for (int j = 1; j <= 50; j++) begin
            btn_pause = (j <= 10);
            sw_adj    = (j >= 2 && j <= 20);
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL adj_wins_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
            if (paused_o) seen_paused = 1'b1;
        end
        n_checks++;
        if (seen_paused || adj_o !== 1'b0) begin
            n_fail++;
            $display("FAIL adj_wins got paused=%b adj=%b exp 0/0", seen_paused, adj_o);
        end
    endtask

    task automatic test_reset_mid();
        logic stale = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                btn_pause = 1'b1;
                repeat (DEB) step();
            end else begin
                sw_adj = 1'b1;
                repeat (DEB + 11) step();
            end
            #2 reset_c = 1'b1;
            model_reset();
            #1;
            n_checks++;
            if (obs !== RESET_VEC) begin
                n_fail++;
                $display("FAIL reset_async s=%0d got=%b exp=%b", s, obs, RESET_VEC);
            end
            btn_pause = 1'b0;
            sw_adj    = 1'b0;
            repeat (2) step();
            reset_c = 1'b0;
            for (int j = 0; j < 20; j++) begin
                step();
                n_checks++;
                if (obs !== m_exp) begin
                    n_fail++;
                    $display("FAIL reset_mid_model t=%0t got=%b exp=%b", $time, obs, m_exp);
                end
                if (paused_o || adj_o) stale = 1'b1;
            end
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL reset_stale_event got=1 exp=0");
        end
    endtask

    task automatic test_random();
        int unsigned hold [4] = '{0, 0, 0, 0};
        for (int j = 0; j < 1500; j++) begin
            if (hold[0] == 0) begin btn_pause = $urandom_range(0, 1); hold[0] = $urandom_range(1, 14); end
            if (hold[1] == 0) begin btn_clr   = $urandom_range(0, 1); hold[1] = $urandom_range(1, 20); end
            if (hold[2] == 0) begin sw_adj    = $urandom_range(0, 1); hold[2] = $urandom_range(1, 40); end
            if (hold[3] == 0) begin sw_sel    = 2'($urandom_range(0, 3)); hold[3] = $urandom_range(1, 10); end
            for (int k = 0; k < 4; k++) hold[k]--;
            step();
            n_checks++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL random_model t=%0t got=%b exp=%b", $time, obs, m_exp);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run();
        test_debounce_pause();
        test_adjust(2'b10);
        test_adjust(2'($urandom_range(0, 3)));
        test_adjust_from_paused();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
